// File: rtl/multicycle_controller_if.sv
// ============================================================================
// multicycle_controller_if : instruction/flag inputs and datapath control bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control;
  logic        add_sub_mode;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        adr_src;
  logic        ir_write;
  logic        reg_write;
  logic        pc_write;
  logic        mem_write;
  logic        instr_retired;
  logic        illegal;
  logic [3:0]  state_dbg;

  modport master (
    input  instr, zero,
    output imm_src, alu_control, add_sub_mode, result_src, alu_src_a,
           alu_src_b, adr_src, ir_write, reg_write, pc_write, mem_write,
           instr_retired, illegal, state_dbg
  );

  modport slave (
    output instr, zero,
    input  imm_src, alu_control, add_sub_mode, result_src, alu_src_a,
           alu_src_b, adr_src, ir_write, reg_write, pc_write, mem_write,
           instr_retired, illegal, state_dbg
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : Moore control FSM sequencing the RV32I multicycle datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_controller #(
  parameter logic [3:0] RESET_STATE     = 4'd0,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_AND  = 4'b0010;
  localparam logic [3:0] c_ALU_OR   = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SLT  = 4'b0101;
  localparam logic [3:0] c_ALU_SLTU = 4'b0110;
  localparam logic [3:0] c_ALU_SLL  = 4'b0111;
  localparam logic [3:0] c_ALU_SRL  = 4'b1000;
  localparam logic [3:0] c_ALU_SRA  = 4'b1001;

  state_t     r_state;
  state_t     w_next_state;
  logic       r_illegal;

  logic [6:0] w_op;
  logic [2:0] w_funct3;
  logic       w_funct7b5;

  logic [3:0] w_alu_control;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_adr_src;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_retire;
  logic [2:0] w_imm_src;
  logic       unused_instr_bits;

  assign w_op       = bus.instr[6:0];
  assign w_funct3   = bus.instr[14:12];
  assign w_funct7b5 = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // funct7b5 selects SUB only for register-register ops; shifts honour it in both forms
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       is_r);
    logic [3:0] op;
    op = c_ALU_ADD;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? c_ALU_SUB : c_ALU_ADD;
      3'b111:  op = c_ALU_AND;
      3'b110:  op = c_ALU_OR;
      3'b100:  op = c_ALU_XOR;
      3'b010:  op = c_ALU_SLT;
      3'b011:  op = c_ALU_SLTU;
      3'b001:  op = c_ALU_SLL;
      3'b101:  op = f7b5 ? c_ALU_SRA : c_ALU_SRL;
      default: op = c_ALU_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= state_t'(RESET_STATE);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == S_TRAP)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_imm_src = 3'b000;
    case (w_op)
      c_OP_STORE:  w_imm_src = 3'b001;
      c_OP_BRANCH: w_imm_src = 3'b010;
      c_OP_JAL:    w_imm_src = 3'b011;
      c_OP_LUI:    w_imm_src = 3'b100;
      default:     w_imm_src = 3'b000;
    endcase
  end

  always_comb begin
    w_next_state  = r_state;
    w_alu_control = c_ALU_ADD;
    w_result_src  = 2'd0;
    w_alu_src_a   = 2'd0;
    w_alu_src_b   = 2'd0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_pc_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_retire      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'd2;
        w_result_src = 2'd2;
        w_pc_write   = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_a = 2'd1;
        w_alu_src_b = 2'd1;
        case (w_op)
          c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
          c_OP_R:                w_next_state = S_EXEC_R;
          c_OP_I:                w_next_state = S_EXEC_I;
          c_OP_JAL:              w_next_state = S_JAL;
          c_OP_LUI:              w_next_state = S_LUI;
          c_OP_BRANCH: begin
            if (w_funct3[2:1] == 2'b00)
              w_next_state = S_BRANCH;
            else
              w_next_state = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end
          default:               w_next_state = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 2'd2;
        w_alu_src_b  = 2'd1;
        // op[5] distinguishes store (0100011) from load (0000011)
        w_next_state = w_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src    = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = 2'd1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXEC_R: begin
        w_alu_src_a   = 2'd2;
        w_alu_control = alu_decode(w_funct3, w_funct7b5, 1'b1);
        w_next_state  = S_ALUWB;
      end
      S_EXEC_I: begin
        w_alu_src_a   = 2'd2;
        w_alu_src_b   = 2'd1;
        w_alu_control = alu_decode(w_funct3, w_funct7b5, 1'b0);
        w_next_state  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a   = 2'd2;
        w_alu_control = c_ALU_SUB;
        w_pc_write    = bus.zero ^ w_funct3[0];
        w_retire      = 1'b1;
        w_next_state  = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a  = 2'd1;
        w_alu_src_b  = 2'd2;
        w_pc_write   = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_LUI: begin
        w_result_src = 2'd3;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_TRAP: begin
        w_next_state = S_TRAP;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign bus.imm_src      = w_imm_src;
  assign bus.alu_control  = w_alu_control;
  assign bus.add_sub_mode = (w_alu_control == c_ALU_SUB) ||
                            (w_alu_control == c_ALU_SLT) ||
                            (w_alu_control == c_ALU_SLTU);
  assign bus.result_src   = w_result_src;
  assign bus.alu_src_a    = w_alu_src_a;
  assign bus.alu_src_b    = w_alu_src_b;
  assign bus.adr_src      = w_adr_src;
  // Strobes are gated by reset so an abandoned instruction leaves no partial write
  assign bus.ir_write      = w_ir_write  & ~reset;
  assign bus.reg_write     = w_reg_write & ~reset;
  assign bus.pc_write      = w_pc_write  & ~reset;
  assign bus.mem_write     = w_mem_write & ~reset;
  assign bus.instr_retired = w_retire    & ~reset;
  assign bus.illegal       = r_illegal;
  assign bus.state_dbg     = r_state;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control unit for the multicycle RV32I core. It sequences data_path through fetch, decode, execute, memory and writeback, producing every datapath control strobe as a Moore function of the current state plus instruction fields. It sits beside data_path in the core top level and consumes instr[31:0] and the zero flag. It also drives the memory write strobe, a retire pulse and an illegal-instruction halt.

Parameters:
- RESET_STATE, 4'd0 (S_FETCH), state entered on reset; any other value is unsupported.
- HALT_ON_ILLEGAL, 1, 1: an illegal opcode parks the FSM in S_TRAP; 0: treated as a NOP and returns to S_FETCH.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- instr  in  32  IR contents (op = [6:0], funct3 = [14:12], funct7b5 = [30])
- zero  in  1  ALU zero flag
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_control  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
- add_sub_mode  out  1  1 whenever alu_control = SUB/SLT/SLTU
- result_src  out  2  0 alu_out, 1 data, 2 alu_result, 3 imm_ext
- alu_src_a  out  2  0 pc, 1 old_pc, 2 A
- alu_src_b  out  2  0 rs2 (write_data), 1 imm_ext, 2 const 4
- adr_src  out  1  0 pc, 1 result
- ir_write, reg_write, pc_write, mem_write  out  1 each  write strobes
- instr_retired  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  sticky; set on entry to S_TRAP
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: state <= S_FETCH asynchronously and illegal <= 0. While reset = 1, ir_write/reg_write/pc_write/mem_write/instr_retired are forced to 0. Reset mid-instruction abandons that instruction with no partial register or memory write.
- All outputs not listed for a state are 0. imm_src is decoded from op in every state: lw/I-ALU gives I, sw gives S, branch gives B, jal gives J, lui gives U, otherwise I.
- S_FETCH: adr_src=0, ir_write=1, src_a=0, src_b=2, ADD, result_src=2, pc_write=1. Next state is S_DECODE.
- S_DECODE: src_a=1, src_b=1, ADD (branch/jump target into alu_out). Next state by op:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXEC_R
  - 0010011 -> S_EXEC_I
  - 1100011 with funct3 in {000, 001} -> S_BRANCH
  - 1101111 -> S_JAL
  - 0110111 -> S_LUI
  - anything else -> S_TRAP (or S_FETCH if HALT_ON_ILLEGAL = 0)
- S_MEMADR: src_a=2, src_b=1, ADD. Load goes to S_MEMREAD; store goes to S_MEMWRITE.
- S_MEMREAD: result_src=0, adr_src=1. Next state is S_MEMWB.
- S_MEMWB: result_src=1, reg_write=1, retire. Next state is S_FETCH.
- S_MEMWRITE: result_src=0, adr_src=1, mem_write=1, retire. Next state is S_FETCH.
- S_EXEC_R: src_a=2, src_b=0, ALU op from funct3/funct7b5:
  - 000: ADD, or SUB if funct7b5 = 1
  - 111: AND; 110: OR; 100: XOR; 010: SLT; 011: SLTU; 001: SLL
  - 101: SRL, or SRA if funct7b5 = 1
  - Next state is S_ALUWB.
- S_EXEC_I: same decode with src_b=1, except funct3 = 000 is always ADD; funct7b5 applies only to 101. Next state is S_ALUWB.
- S_ALUWB: result_src=0, reg_write=1, retire. Next state is S_FETCH.
- S_BRANCH: src_a=2, src_b=0, SUB, result_src=0, pc_write = zero XOR funct3[0] (beq/bne), retire. Next state is S_FETCH.
- S_JAL: src_a=1, src_b=2, ADD, result_src=0, pc_write=1. Next state is S_ALUWB, which writes old_pc+4 to rd.
- S_LUI: result_src=3, reg_write=1, retire. Next state is S_FETCH.
- S_TRAP: all strobes 0, illegal=1. Leaves only on reset.
- Cycle counts: lw 5; sw, R, I and jal 4; beq/bne and lui 3.
- The zero input is sampled only in S_BRANCH; a combinational change of zero in other states has no effect.

Test Plan:
- Reset asserted mid-S_MEMWRITE (sw 0x00502423) -> mem_write drops asynchronously to 0 and state_dbg = S_FETCH. First post-reset cycle: ir_write=1, pc_write=1, src_b=2.
- add x3,x1,x2 (0x002081B3) -> state sequence FETCH, DECODE, EXEC_R, ALUWB. In EXEC_R alu_control=0000; reg_write=1 and instr_retired=1 only in cycle 4.
- sub 0x402081B3 gives SUB with add_sub_mode=1. addi with funct7b5=1 (0x40008093) gives ADD. srai 0x4010D093 gives SRA.
- lw x5,4(x0) (0x00402283) -> 5 cycles; adr_src=1 in MEMREAD; result_src=1 and reg_write=1 in MEMWB. sw 0x00502423 -> imm_src=001 and mem_write=1 in cycle 4 only.
- beq 0x00208463: zero=1 gives pc_write=1, zero=0 gives pc_write=0. bne 0x00209463 gives the inverse. Either way 3 cycles, reg_write never asserted.
- jal 0x010000EF -> JAL state has pc_write=1, then ALUWB has reg_write=1. lui 0x123452B7 -> result_src=3, imm_src=100. Opcode 0x0000007F -> S_TRAP, illegal=1, no strobes until reset.
